chip8_sprite_engine: RTL
========================

CHIP8_SPRITE_ENGINE -- requirements
Module: chip8_sprite_engine

Interface
REQ-001 SHALL have parameter DISP_W, 128, physical framebuffer width in pixels; power of two, at least 16.
REQ-002 SHALL have parameter DISP_H, 64, physical framebuffer height in pixels; power of two, at least 16.
REQ-003 SHALL have parameter ADDR_W, 12, sprite memory address width.
REQ-004 SHALL have port instruction_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  draw request, sampled only in IDLE.
REQ-007 SHALL have port clr  in  1  clear-screen request, sampled only in IDLE.
REQ-008 SHALL have port hires  in  1  1 = full DISP_W x DISP_H plane; 0 = DISP_W/2 x DISP_H/2 plane.
REQ-009 SHALL have port wrap  in  1  1 = pixels past an edge wrap; 0 = pixels past an edge are clipped.
REQ-010 SHALL have port x_in  in  8  sprite column.
REQ-011 SHALL have port y_in  in  8  sprite row.
REQ-012 SHALL have port n_in  in  4  sprite row count.
REQ-013 SHALL have port i_addr  in  ADDR_W  sprite base address.
REQ-014 SHALL have port mem_addr  out  ADDR_W  sprite byte read address.
REQ-015 SHALL have port mem_rd  out  1  read strobe; mem_data is valid exactly one cycle after the strobe.
REQ-016 SHALL have port mem_data  in  8  sprite byte.
REQ-017 SHALL have port busy  out  1  draw in progress.
REQ-018 SHALL have port done  out  1  one-cycle draw-complete pulse.
REQ-019 SHALL have port vf  out  1  collision flag.
REQ-020 SHALL have port display  out  DISP_W*DISP_H  framebuffer; bit index = row*DISP_W + col; col 0 is leftmost.

Function
REQ-021 SHALL implement states IDLE, FETCH_HI, FETCH_LO, DRAW and DONE.
REQ-022 In IDLE, SHALL give clr priority over start: clr zeroes display on the next edge, start is dropped, and no done pulse is produced.
REQ-023 When start is accepted, SHALL latch x_in, y_in, n_in, i_addr, hires and wrap; later input changes SHALL have no effect until the next start.
REQ-024 SHALL ignore start and clr while busy.
REQ-025 SHALL use the active plane W_eff x H_eff, which is the full plane when hires=1 and the half plane when hires=0; only the top-left W_eff x H_eff region is ever modified.
REQ-026 SHALL compute the origin as x0 = x_in mod W_eff and y0 = y_in mod H_eff, regardless of wrap.
REQ-027 SHALL draw an 8x n_in sprite when n_in != 0, fetching byte r at address i_addr + r.
REQ-028 When hires=1 and n_in=0, SHALL draw a 16x16 sprite; row r is the high byte at i_addr + 2r followed by the low byte at i_addr + 2r + 1.
REQ-029 When hires=0 and n_in=0, SHALL draw zero rows and go directly to DONE with vf=0.
REQ-030 SHALL wrap all address arithmetic modulo 2^ADDR_W.
REQ-031 SHALL map sprite bit MSB to column x0 (for a 16-wide row, the high-byte MSB); sprite row r maps to display row y0 + r.
REQ-032 When wrap=1, SHALL place out-of-range columns and rows at their value mod W_eff and mod H_eff respectively.
REQ-033 When wrap=0, SHALL leave pixels with column >= W_eff, or rows >= H_eff, unmodified; a clipped row SHALL still be fetched, keeping timing independent of position.
REQ-034 SHALL XOR each set sprite pixel into its display bit.
REQ-035 SHALL set vf to 1 if any display bit goes from 1 to 0 during the draw, else 0; clipped pixels never collide.
REQ-036 SHALL hold vf stable from done until the next accepted start.
REQ-037 For an 8-wide row, SHALL spend one FETCH_LO cycle (mem_rd=1, mem_addr driven) followed by one DRAW cycle (byte used, row written): 2 cycles per row.
REQ-038 For a 16-wide row, SHALL spend FETCH_HI, then FETCH_LO (high byte latched), then DRAW: 3 cycles per row.
REQ-039 SHALL hold busy high from the edge after start acceptance through the DONE cycle inclusive.
REQ-040 SHALL assert done in DONE for exactly one cycle, then return to IDLE.
REQ-041 SHALL assert done at edge k after acceptance, where k = 2*n_in+1 for 8-wide sprites, 49 for 16x16, and 1 for a zero-row draw.
REQ-042 SHALL hold mem_rd at 0 outside FETCH states.
REQ-043 SHALL allow a new start to be accepted in the cycle immediately after DONE.

Reset
REQ-044 On rst, SHALL on the next edge force IDLE, display=0, vf=0, busy=0, done=0, mem_rd=0 and mem_addr=0.
REQ-045 SHALL apply rst with priority over start and clr.
REQ-046 SHALL abort any draw in progress on rst, with no done pulse.

Verification
REQ-047 Lores draw: hires=0, wrap=1, x=0, y=0, n=5, memory 0xF0,0x90,0x90,0x90,0xF0 -> done at edge 11, vf=0, display row 0 cols 0-3 = 1, rows 1-3 cols 0 and 3 = 1.
REQ-048 Repeat identical draw -> those pixels return to 0, vf=1.
REQ-049 Wrap versus clip: hires=1, x=126, y=63, n=2, bytes 0xFF,0xFF. With wrap=1, rows 63 and 0 have cols 126,127,0-5 set. With wrap=0, only row 63 cols 126-127 are set, and done is still at edge 5.
REQ-050 Hires 16x16 draw: n=0, 32 bytes 0xFF -> done at edge 49, display shows a 16x16 block; a lores n=0 draw -> done at edge 1, display unchanged.
REQ-051 start and clr asserted together in IDLE -> display cleared, no draw, no done; start during busy -> ignored.
REQ-052 rst asserted at edge 4 of a 5-row draw -> no done pulse, display=0, busy=0, and the next start behaves normally.

Source files
------------

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine: CHIP-8/SCHIP sprite fetch and XOR-draw engine over a packed framebuffer.
module chip8_sprite_engine #(
  parameter int DISP_W = 128,
  parameter int DISP_H = 64,
  parameter int ADDR_W = 12
) (
  input  logic                       instruction_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clr,
  input  logic                       hires,
  input  logic                       wrap,
  input  logic [7:0]                 x_in,
  input  logic [7:0]                 y_in,
  input  logic [3:0]                 n_in,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd,
  input  logic [7:0]                 mem_data,
  output logic                       busy,
  output logic                       done,
  output logic                       vf,
  output logic [DISP_W*DISP_H-1:0]   display
);
  localparam int CW = $clog2(DISP_W);
  localparam int RW = $clog2(DISP_H);
  typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, DRAW, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_x0;
  logic [RW-1:0] r_y0;
  logic [3:0] r_row, r_last;
  logic r_hires, r_wrap, r_wide, r_vf;
  logic [7:0] r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [DISP_W*DISP_H-1:0] r_disp;
  logic w_accept, w_hit;
  logic [CW-1:0] w_cmask_in, w_cmask;
  logic [RW-1:0] w_rmask_in, w_rmask;
  logic [CW:0] w_weff;
  logic [RW:0] w_heff, w_rs;
  logic [CW:0] w_cs [16];
  logic [CW+RW-1:0] w_idx [16];
  logic [15:0] w_pat, w_en;
  always_comb begin
    w_accept = r_state == IDLE && start && !clr;
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_accept ? (n_in != 4'd0 ? FETCH_LO : hires ? FETCH_HI : DONE) : IDLE;
      FETCH_HI: w_next = FETCH_LO;
      FETCH_LO: w_next = DRAW;
      DRAW:     w_next = r_row == r_last ? DONE : r_wide ? FETCH_HI : FETCH_LO;
      default:  w_next = IDLE;
    endcase
  end
  // Masks give "mod W_eff / H_eff" for free because both planes are powers of two.
  always_comb begin
    w_cmask_in = hires ? '1 : {1'b0, {(CW-1){1'b1}}};
    w_rmask_in = hires ? '1 : {1'b0, {(RW-1){1'b1}}};
    w_cmask = r_hires ? '1 : {1'b0, {(CW-1){1'b1}}};
    w_rmask = r_hires ? '1 : {1'b0, {(RW-1){1'b1}}};
    w_weff = r_hires ? (CW+1)'(DISP_W) : (CW+1)'(DISP_W/2);
    w_heff = r_hires ? (RW+1)'(DISP_H) : (RW+1)'(DISP_H/2);
    w_pat = r_wide ? {r_hi, mem_data} : {mem_data, 8'h00};
    w_rs = {1'b0, r_y0} + (RW+1)'(r_row);
    w_hit = 1'b0;
    for (int j = 0; j < 16; j++) begin
      w_cs[j] = {1'b0, r_x0} + (CW+1)'(j);
      w_en[j] = r_state == DRAW && w_pat[15-j] && (r_wrap || (w_cs[j] < w_weff && w_rs < w_heff));
      w_idx[j] = {w_rs[RW-1:0] & w_rmask, w_cs[j][CW-1:0] & w_cmask};
      w_hit = w_hit | (w_en[j] & r_disp[w_idx[j]]);
    end
  end
  always_ff @(posedge instruction_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_disp <= '0;
      r_vf <= 1'b0;
      r_addr <= '0;
      r_row <= '0;
      r_last <= '0;
      r_x0 <= '0;
      r_y0 <= '0;
      r_hires <= 1'b0;
      r_wrap <= 1'b0;
      r_wide <= 1'b0;
      r_hi <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && clr) r_disp <= '0;
      if (w_accept) begin
        r_x0 <= CW'(x_in) & w_cmask_in;
        r_y0 <= RW'(y_in) & w_rmask_in;
        r_hires <= hires;
        r_wrap <= wrap;
        r_wide <= hires && n_in == 4'd0;
        r_last <= n_in == 4'd0 ? 4'hF : n_in - 4'd1;
        r_row <= '0;
        r_addr <= i_addr;
        r_vf <= 1'b0;
      end
      if (r_state == FETCH_HI || r_state == FETCH_LO) r_addr <= r_addr + 1'b1;
      if (r_state == FETCH_LO) r_hi <= mem_data;
      if (r_state == DRAW) begin
        r_row <= r_row + 4'd1;
        if (w_hit) r_vf <= 1'b1;
        for (int j = 0; j < 16; j++)
          if (w_en[j]) r_disp[w_idx[j]] <= ~r_disp[w_idx[j]];
      end
    end
  end
  assign mem_addr = r_addr;
  assign mem_rd = r_state == FETCH_HI || r_state == FETCH_LO;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign vf = r_vf;
  assign display = r_disp;
endmodule
